// File: rtl/final_logic_param.sv
// Final routing stage: drains NUM_VC FIFO heads into NUM_DEST output buffers.
// The grant is strict-priority or round-robin. Underflow and bad-destination pops raise one-cycle pulses.
module final_logic_param #(
   parameter int DATA_W    = 6,
   parameter int NUM_VC    = 2,
   parameter int NUM_DEST  = 2,
   parameter int OUT_DEPTH = 4,
   parameter int ARB_MODE  = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_VC*DATA_W-1:0]   data_in_vc,
   input  logic [NUM_VC-1:0]          empty_vc,
   output logic [NUM_VC-1:0]          pop_vc,
   input  logic [NUM_DEST-1:0]        dest_pop,
   output logic [NUM_DEST*DATA_W-1:0] data_out_dest,
   output logic [NUM_DEST-1:0]        valid_dest,
   output logic [NUM_DEST-1:0]        error_dest,
   output logic [NUM_DEST-1:0]        empty_dest,
   output logic [NUM_DEST-1:0]        full_dest,
   output logic                       route_error
);
   localparam int DEST_W = $clog2(NUM_DEST);
   localparam int VC_W   = $clog2(NUM_VC);
   localparam int PTR_W  = $clog2(OUT_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_DEPTH);

   logic [DATA_W-1:0] mem_q      [NUM_DEST][OUT_DEPTH];
   logic [DATA_W-1:0] mem_d      [NUM_DEST][OUT_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q   [NUM_DEST];
   logic [PTR_W-1:0]  wr_ptr_d   [NUM_DEST];
   logic [PTR_W-1:0]  rd_ptr_q   [NUM_DEST];
   logic [PTR_W-1:0]  rd_ptr_d   [NUM_DEST];
   logic [CNT_W-1:0]  cnt_q      [NUM_DEST];
   logic [CNT_W-1:0]  cnt_d      [NUM_DEST];
   logic [DATA_W-1:0] data_out_q [NUM_DEST];
   logic [DATA_W-1:0] data_out_d [NUM_DEST];
   logic [NUM_DEST-1:0] valid_q, valid_d, error_q, error_d;
   logic [NUM_DEST-1:0] empty_q, empty_d, full_q, full_d;
   logic [NUM_DEST-1:0] push_v, pop_v;
   logic                route_error_q, route_error_d;
   logic [VC_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic [DATA_W-1:0] vc_word [NUM_VC];
   logic [DEST_W-1:0] vc_dest [NUM_VC];
   logic [NUM_VC-1:0] vc_bad, vc_elig;
   logic              gnt;
   logic [VC_W-1:0]   gnt_idx;

   // A VC with a bad destination is always eligible so it can be flushed.
   always_comb begin
      for (int k = 0; k < NUM_VC; k++) begin
         vc_word[k] = data_in_vc[k*DATA_W +: DATA_W];
         vc_dest[k] = vc_word[k][DATA_W-1 -: DEST_W];
         vc_bad[k]  = 32'(vc_dest[k]) >= 32'(NUM_DEST);
         vc_elig[k] = 1'b0;
         if (!empty_vc[k]) begin
            if (vc_bad[k]) vc_elig[k] = 1'b1;
            else vc_elig[k] = (cnt_q[vc_dest[k]] != CNT_FULL) || dest_pop[vc_dest[k]];
         end
      end
   end

   always_comb begin
      int j;
      j       = 0;
      gnt     = 1'b0;
      gnt_idx = '0;
      if (ARB_MODE == 0) begin
         for (int k = NUM_VC-1; k >= 0; k--) begin
            if (vc_elig[k]) begin
               gnt     = 1'b1;
               gnt_idx = VC_W'(k);
            end
         end
      end else begin
         for (int i = NUM_VC-1; i >= 0; i--) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_VC) j = j - NUM_VC;
            if (vc_elig[j]) begin
               gnt     = 1'b1;
               gnt_idx = VC_W'(j);
            end
         end
      end
      if (reset) gnt = 1'b0;
      pop_vc = '0;
      if (gnt) pop_vc[gnt_idx] = 1'b1;
      rr_ptr_d = rr_ptr_q;
      if (gnt) rr_ptr_d = (gnt_idx == VC_W'(NUM_VC-1)) ? '0 : gnt_idx + VC_W'(1);
      route_error_d = gnt && vc_bad[gnt_idx];
   end

   // Pops act on the count at cycle start, so a same-cycle push never hides an underflow.
   always_comb begin
      mem_d  = mem_q;
      push_v = '0;
      pop_v  = '0;
      for (int d = 0; d < NUM_DEST; d++) begin
         pop_v[d]      = dest_pop[d] && (cnt_q[d] != '0);
         push_v[d]     = gnt && !vc_bad[gnt_idx] && (vc_dest[gnt_idx] == DEST_W'(d));
         wr_ptr_d[d]   = wr_ptr_q[d];
         rd_ptr_d[d]   = rd_ptr_q[d];
         data_out_d[d] = data_out_q[d];
         valid_d[d]    = pop_v[d];
         error_d[d]    = dest_pop[d] && (cnt_q[d] == '0);
         if (push_v[d]) begin
            mem_d[d][wr_ptr_q[d]] = vc_word[gnt_idx];
            wr_ptr_d[d]           = wr_ptr_q[d] + PTR_W'(1);
         end
         if (pop_v[d]) begin
            data_out_d[d] = mem_q[d][rd_ptr_q[d]];
            rd_ptr_d[d]   = rd_ptr_q[d] + PTR_W'(1);
         end
         cnt_d[d]   = cnt_q[d] + CNT_W'(push_v[d]) - CNT_W'(pop_v[d]);
         empty_d[d] = (cnt_d[d] == '0);
         full_d[d]  = (cnt_d[d] == CNT_FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int d = 0; d < NUM_DEST; d++) begin
            wr_ptr_q[d]   <= '0;
            rd_ptr_q[d]   <= '0;
            cnt_q[d]      <= '0;
            data_out_q[d] <= '0;
         end
         valid_q       <= '0;
         error_q       <= '0;
         empty_q       <= '1;
         full_q        <= '0;
         route_error_q <= 1'b0;
         rr_ptr_q      <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         data_out_q    <= data_out_d;
         valid_q       <= valid_d;
         error_q       <= error_d;
         empty_q       <= empty_d;
         full_q        <= full_d;
         route_error_q <= route_error_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   // Storage needs no reset: pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      data_out_dest = '0;
      for (int d = 0; d < NUM_DEST; d++) data_out_dest[d*DATA_W +: DATA_W] = data_out_q[d];
   end

   assign valid_dest  = valid_q;
   assign error_dest  = error_q;
   assign empty_dest  = empty_q;
   assign full_dest   = full_q;
   assign route_error = route_error_q;

endmodule

// File: doc/final_logic_param.md
Name: final_logic_param

Overview:
- Parametrised successor to the two-VC/two-destination final routing stage of the PCIe transmission layer.
- Drains NUM_VC virtual-channel FIFOs (first-word-fall-through heads) and routes each word by its destination field into one of NUM_DEST per-destination output buffers.
- Downstream consumers read these buffers with a pop/valid handshake.
- Adds selectable strict-priority or round-robin arbitration, no head-of-line blocking across VCs, buffered outputs, and per-destination underflow and route-error reporting.

Parameters:
DATA_W, 6, word width; destination field is bits [DATA_W-1 -: DEST_W], DEST_W = clog2(NUM_DEST)
NUM_VC, 2, number of input virtual channels (>=2)
NUM_DEST, 2, number of destinations (>=2, need not be power of 2)
OUT_DEPTH, 4, entries per destination output buffer (power of 2, >=2)
ARB_MODE, 0, 0 = strict priority (VC0 highest), 1 = round robin

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in_vc  in  NUM_VC*DATA_W  head word of each VC FIFO, VCk at [k*DATA_W +: DATA_W]
empty_vc  in  NUM_VC  VC FIFO empty flags
pop_vc  out  NUM_VC  one-hot-or-zero pop to VC FIFOs, combinational
dest_pop  in  NUM_DEST  downstream read request per destination
data_out_dest  out  NUM_DEST*DATA_W  registered read data per destination
valid_dest  out  NUM_DEST  data_out_dest slice valid this cycle
error_dest  out  NUM_DEST  one-cycle pulse: pop on empty buffer
empty_dest  out  NUM_DEST  output buffer empty, registered
full_dest  out  NUM_DEST  output buffer full, registered
route_error  out  1  one-cycle pulse: popped word had destination field >= NUM_DEST

Interface: one clock, clk; reset is synchronous and active-high.

Behaviour:
- Reset (sampled high at edge):
  - Clears all buffer pointers and counts.
  - data_out_dest=0, valid_dest=0, error_dest=0, route_error=0, empty_dest=all 1, full_dest=0.
  - Round-robin pointer = 0.
  - pop_vc is forced 0 while reset is high. Reset mid-operation discards all buffered words.
- Eligibility of VCk: !empty_vc[k] and (dest field invalid, or target buffer not full, or target buffer full with dest_pop asserted this cycle).
- Grant: at most one VC per cycle. pop_vc[k]=1 for the granted VC, in the same cycle (combinational from inputs and registered state).
  - ARB_MODE=0: lowest-index eligible VC.
  - ARB_MODE=1: first eligible VC searching from rr_ptr upward, with wrap. On a grant to k, rr_ptr <= (k+1) mod NUM_VC. No grant leaves the pointer unchanged.
- No head-of-line blocking: an ineligible VC (its target is full) does not block other eligible VCs.
- Push: at the edge, the granted word is written into its destination buffer. Latency VC head -> buffer = 1 cycle. Buffer -> data_out_dest = 1 cycle after dest_pop.
- Route error: a granted word whose destination field is >= NUM_DEST is popped and discarded. route_error pulses the next cycle and no buffer is written.
- Downstream read:
  - If dest_pop[d] is asserted and buffer d is non-empty at cycle start, data_out_dest[d] <= head and valid_dest[d] <= 1 the next cycle.
  - Otherwise valid_dest[d] <= 0 and data_out_dest[d] holds its last value.
- Underflow: dest_pop[d] asserted with buffer d empty at cycle start -> error_dest[d] pulses the next cycle and the buffer is unchanged. This holds even if a push to d happens in the same cycle; that push is still stored.
- Simultaneous push and pop on the same buffer: count unchanged, both succeed, including when the buffer is full.
- Pointers wrap modulo OUT_DEPTH. Count width is clog2(OUT_DEPTH)+1.
- empty_dest/full_dest reflect the post-edge count.
- Word order is preserved per (VC, destination) pair. Interleaving across VCs follows the grant order.

Test Plan:
(Defaults: DATA_W=6, NUM_VC=2, NUM_DEST=2, OUT_DEPTH=4; dest = bit 5.)
1. Reset high 2 cycles with empty_vc=2'b00 -> pop_vc=0; all outputs at reset values; empty_dest=2'b11.
2. ARB_MODE=0; VC0 head 6'h05, VC1 head 6'h21, both non-empty 1 cycle -> pop_vc=2'b01. Next cycle VC0 empty -> pop_vc=2'b10. dest_pop=2'b11 afterwards -> data_out_dest D0=6'h05, D1=6'h21, valid_dest=2'b11.
3. ARB_MODE=1; both VCs continuously non-empty -> pop_vc alternates 01,10,01,10 starting with 01 after reset.
4. Fill D0 buffer with 4 words (full_dest[0]=1); VC0 head targets D0 and VC1 head 6'h2A targets D1 -> VC1 granted, VC0 held. Add dest_pop[0]=1 in the same cycle -> VC0 becomes eligible and the D0 count stays 4.
5. dest_pop[1]=1 with D1 empty -> error_dest[1]=1 for exactly 1 cycle, valid_dest[1]=0. Repeat with NUM_DEST=3 and VC0 head 6'h30 (dest 3) -> popped, route_error pulses, no buffer written.
6. Assert reset mid-stream with 3 words in D0 -> next cycle empty_dest[0]=1, valid_dest=0, rr_ptr=0. Subsequent words are delivered in order.
